// File: rtl/ysyx_22041207_mul_ctrl_pkg.sv
// Shared definitions for the multiplier request controller.
//   mul_op_t : requester operation encoding (MUL/MULH/MULHSU/MULHU)
//   state_t  : controller FSM states
//   TAG_W_DEF, WDOG_DEF : default tag width and WAIT watchdog limit
//   ext64, src1_signed, src2_signed : operand extension helpers
package ysyx_22041207_mul_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_MUL    = 2'd0,
    OP_MULH   = 2'd1,
    OP_MULHSU = 2'd2,
    OP_MULHU  = 2'd3
  } mul_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam int unsigned TAG_W_DEF = 4;
  localparam int unsigned WDOG_DEF  = 48;

  function automatic logic [63:0] ext64(input logic [31:0] v, input logic sgn);
    return {{32{sgn & v[31]}}, v};
  endfunction

  function automatic logic src1_signed(input mul_op_t op);
    return (op == OP_MULH) || (op == OP_MULHSU);
  endfunction

  function automatic logic src2_signed(input mul_op_t op);
    return (op == OP_MULH);
  endfunction

endpackage

// File: rtl/ysyx_22041207_rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, rst : clock, asynchronous active-high reset (pointer -> 0)
//   req      : request vector
//   en       : a grant is being taken this cycle; advances the pointer
//   gnt      : one-hot (or zero) combinational grant
// After a grant to requester N, requester 1-N has priority next time.
module ysyx_22041207_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  // ptr names the requester that wins a simultaneous contest
  logic ptr;

  always_comb begin
    gnt[0] = req[0] & (~ptr | ~req[1]);
    gnt[1] = req[1] & ( ptr | ~req[0]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (en && (|req)) begin
      ptr <= gnt[0];
    end
  end

endmodule

// File: rtl/ysyx_22041207_mul_ctrl.sv
// Multiplier request controller: arbitrates two requesters onto one
// iterative multiplier, issues the operation, waits for the result with a
// watchdog, and returns a tagged response.
//   clk, rst            : clock, asynchronous active-high reset
//   req_valid/req_ready : per-requester handshake (ready is same-cycle)
//   req_op/src1/src2/tag: per-requester operation, operands, tag
//   resp_*              : registered response channel, held until resp_ready
//   kill                : flush; abandons the in-flight operation
//   mul_valid/mul_ready : issue handshake to the multiplier
//   mul_flush           : one-cycle abort pulse to the multiplier
//   mul_multiplicand/mul_multiplier : 64-bit extended operands
//   mul_out_valid, mul_result_hi/lo : multiplier result
module ysyx_22041207_mul_ctrl
  import ysyx_22041207_mul_ctrl_pkg::*;
#(
  parameter int unsigned TAG_W = TAG_W_DEF,
  parameter int unsigned WDOG  = WDOG_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0][1:0]       req_op,
  input  logic [1:0][31:0]      req_src1,
  input  logic [1:0][31:0]      req_src2,
  input  logic [1:0][TAG_W-1:0] req_tag,
  output logic                  resp_valid,
  output logic                  resp_id,
  output logic [TAG_W-1:0]      resp_tag,
  output logic [31:0]           resp_data,
  output logic                  resp_err,
  input  logic                  resp_ready,
  input  logic                  kill,
  output logic                  mul_valid,
  output logic                  mul_flush,
  output logic [63:0]           mul_multiplicand,
  output logic [63:0]           mul_multiplier,
  input  logic                  mul_ready,
  input  logic                  mul_out_valid,
  input  logic [31:0]           mul_result_hi,
  input  logic [31:0]           mul_result_lo
);

  localparam int unsigned CNT_W = (WDOG > 1) ? $clog2(WDOG) : 1;

  state_t           state;
  mul_op_t          op_q;
  logic [CNT_W-1:0] wdog_cnt;
  logic [1:0]       gnt;
  logic             grant_en;
  logic             sel;
  mul_op_t          sel_op;

  ysyx_22041207_rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (req_valid),
    .en  (grant_en),
    .gnt (gnt)
  );

  // req_ready and mul_valid are combinational so each handshake completes in
  // the cycle it is offered; the rst term keeps req_ready low during reset.
  always_comb begin
    grant_en  = (state == S_IDLE) && !kill && !rst;
    req_ready = grant_en ? gnt : '0;
    mul_valid = (state == S_ISSUE) && mul_ready && !kill;
    sel       = gnt[1];
    sel_op    = mul_op_t'(req_op[sel]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= S_IDLE;
      op_q             <= OP_MUL;
      wdog_cnt         <= '0;
      resp_valid       <= 1'b0;
      resp_id          <= 1'b0;
      resp_tag         <= '0;
      resp_data        <= '0;
      resp_err         <= 1'b0;
      mul_flush        <= 1'b0;
      mul_multiplicand <= '0;
      mul_multiplier   <= '0;
    end else begin
      mul_flush <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!kill && (|req_valid)) begin
            op_q             <= sel_op;
            resp_id          <= sel;
            resp_tag         <= req_tag[sel];
            mul_multiplicand <= ext64(req_src1[sel], src1_signed(sel_op));
            mul_multiplier   <= ext64(req_src2[sel], src2_signed(sel_op));
            state            <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (kill) begin
            mul_flush <= 1'b1;
            state     <= S_IDLE;
          end else if (mul_ready) begin
            wdog_cnt <= '0;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (kill) begin
            mul_flush <= 1'b1;
            state     <= S_IDLE;
          end else if (mul_out_valid) begin
            resp_data  <= (op_q == OP_MUL) ? mul_result_lo : mul_result_hi;
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
            state      <= S_RESP;
          end else if (wdog_cnt == CNT_W'(WDOG - 1)) begin
            // this is the WDOG-th WAIT cycle without a result
            mul_flush  <= 1'b1;
            resp_data  <= '0;
            resp_err   <= 1'b1;
            resp_valid <= 1'b1;
            state      <= S_RESP;
          end else begin
            wdog_cnt <= wdog_cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (kill || resp_ready) begin
            resp_valid <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22041207_mul_ctrl.sv
// Directed bench for ysyx_22041207_mul_ctrl with a latency-programmable
// multiplier stub and an in-order response scoreboard.
module tb_ysyx_22041207_mul_ctrl;

  localparam int unsigned TW = 4;
  localparam int unsigned WD = 48;

  typedef struct packed {
    logic          id;
    logic [TW-1:0] tag;
    logic [31:0]   data;
    logic          err;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [1:0][1:0]    req_op;
  logic [1:0][31:0]   req_src1;
  logic [1:0][31:0]   req_src2;
  logic [1:0][TW-1:0] req_tag;
  logic               resp_valid;
  logic               resp_id;
  logic [TW-1:0]      resp_tag;
  logic [31:0]        resp_data;
  logic               resp_err;
  logic               resp_ready;
  logic               kill;
  logic               mul_valid;
  logic               mul_flush;
  logic [63:0]        mul_multiplicand;
  logic [63:0]        mul_multiplier;
  logic               mul_ready;
  logic               mul_out_valid;
  logic [31:0]        mul_result_hi;
  logic [31:0]        mul_result_lo;

  int   vectors = 0;
  int   miscompares = 0;
  int   viol = 0;
  exp_t scb[$];

  int          lat = 3;
  bit          stub_never = 1'b0;
  int          stub_cnt;
  logic [63:0] stub_prod;

  always #5 clk = ~clk;

  ysyx_22041207_mul_ctrl #(.TAG_W(TW), .WDOG(WD)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_op           (req_op),
    .req_src1         (req_src1),
    .req_src2         (req_src2),
    .req_tag          (req_tag),
    .resp_valid       (resp_valid),
    .resp_id          (resp_id),
    .resp_tag         (resp_tag),
    .resp_data        (resp_data),
    .resp_err         (resp_err),
    .resp_ready       (resp_ready),
    .kill             (kill),
    .mul_valid        (mul_valid),
    .mul_flush        (mul_flush),
    .mul_multiplicand (mul_multiplicand),
    .mul_multiplier   (mul_multiplier),
    .mul_ready        (mul_ready),
    .mul_out_valid    (mul_out_valid),
    .mul_result_hi    (mul_result_hi),
    .mul_result_lo    (mul_result_lo)
  );

  // Multiplier stub: result appears lat cycles after the accepting edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      stub_cnt  <= 0;
      stub_prod <= '0;
    end else if (mul_flush) begin
      stub_cnt <= 0;
    end else if (mul_valid && mul_ready) begin
      stub_cnt  <= stub_never ? 0 : lat;
      stub_prod <= mul_multiplicand * mul_multiplier;
    end else if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
    end
  end
  assign mul_out_valid = (stub_cnt == 1);
  assign mul_result_hi = stub_prod[63:32];
  assign mul_result_lo = stub_prod[31:0];

  // Protocol monitor: issue without ready, double grant, flush with issue.
  always @(posedge clk) begin
    if ((mul_valid && !mul_ready) || (&req_ready) || (mul_flush && mul_valid))
      viol <= viol + 1;
  end

  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sbv, ua, ub;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    case (op)
      2'd0: begin p = ua * ub; return p[31:0]; end
      2'd1: p = sa * sbv;
      2'd2: p = sa * ub;
      default: p = ua * ub;
    endcase
    return p[63:32];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic id, input logic [TW-1:0] tag, input logic [31:0] d,
                      input logic err);
    scb.push_back({id, tag, d, err});
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_req_ready"}, 64'(req_ready), 64'd0);
    chk({pfx, "_resp"}, 64'({resp_valid, resp_id, resp_tag, resp_data, resp_err}), 64'd0);
    chk({pfx, "_mul_ctl"}, 64'({mul_valid, mul_flush}), 64'd0);
    chk({pfx, "_mcand"}, mul_multiplicand, 64'd0);
    chk({pfx, "_mplier"}, mul_multiplier, 64'd0);
  endtask

  // Offer a request and return at the negedge after it was accepted (ISSUE).
  task automatic do_req(input int r, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [TW-1:0] tag);
    bit ok;
    req_valid[r] = 1'b1;
    req_op[r]    = op;
    req_src1[r]  = a;
    req_src2[r]  = b;
    req_tag[r]   = tag;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (req_ready[r]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("req_accept", 64'(ok), 64'd1);
    @(negedge clk);
    req_valid[r] = 1'b0;
  endtask

  // Wait for a response, hold it off for 'hold' cycles, then accept it.
  task automatic get_resp(input int hold, output int n);
    exp_t e;
    n = 0;
    while (!resp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    e = (scb.size() != 0) ? scb.pop_front() : '0;
    chk("resp_seen", 64'(resp_valid), 64'd1);
    for (int i = 0; i < hold; i++) begin
      chk("resp_hold", 64'({resp_valid, resp_id, resp_tag, resp_data, resp_err}),
          64'({1'b1, e}));
      @(negedge clk);
    end
    chk("resp_fields", 64'({resp_valid, resp_id, resp_tag, resp_data, resp_err}),
        64'({1'b1, e}));
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("resp_drop", 64'(resp_valid), 64'd0);
  endtask

  task automatic set_payload(input int r, input int k);
    req_op[r]   = 2'd0;
    req_src1[r] = 32'(k * 3 + 1 + 100 * r);
    req_src2[r] = 32'd7;
    req_tag[r]  = TW'(1 + k + 8 * r);
  endtask

  initial begin
    int   n;
    int   kk[2];
    int   grants;
    int   resps;
    logic [1:0] pend;
    bit   drop;
    bit   seen;
    int   r;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [TW-1:0] tg;
    exp_t e;

    rst = 1'b1; kill = 1'b0; resp_ready = 1'b0; mul_ready = 1'b1;
    req_op = '0; req_src1 = '0; req_src2 = '0; req_tag = '0;
    kk[0] = 0; kk[1] = 0;
    set_payload(0, 0);
    set_payload(1, 0);
    req_valid = 2'b11;

    // Reset state, then both requesters valid continuously from reset.
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("rst0");
    @(negedge clk);
    rst = 1'b0;
    resp_ready = 1'b1;
    grants = 0; resps = 0; pend = '0; drop = 1'b0;
    for (int cyc = 0; cyc < 300 && resps < 4; cyc++) begin
      #1;
      for (int q = 0; q < 2; q++) begin
        if (pend[q]) begin
          kk[q]++;
          set_payload(q, kk[q]);
          pend[q] = 1'b0;
        end
      end
      if (drop) req_valid = 2'b00;
      if (resp_valid) begin
        e = (scb.size() != 0) ? scb.pop_front() : '0;
        chk("rr_resp", 64'({resp_id, resp_tag, resp_data, resp_err}), 64'(e));
        resps++;
      end
      if (req_ready != 2'b00) begin
        r = req_ready[1] ? 1 : 0;
        chk("rr_order", 64'(r), 64'(grants % 2));
        push(1'(r), req_tag[r], ref_mul(2'd0, req_src1[r], req_src2[r]), 1'b0);
        pend[r] = 1'b1;
        grants++;
        if (grants == 4) drop = 1'b1;
      end
      @(negedge clk);
    end
    chk("rr_resp_count", 64'(resps), 64'd4);
    resp_ready = 1'b0;
    req_valid = 2'b00;
    @(negedge clk);

    // MUL 3 x 0xFFFFFFFE from requester 0; best-case latency.
    lat = 3;
    do_req(0, 2'd0, 32'd3, 32'hFFFF_FFFE, 4'h3);
    push(1'b0, 4'h3, 32'hFFFF_FFFA, 1'b0);
    get_resp(0, n);
    chk("latency_l3", 64'(n), 64'(lat + 1));

    // High-half ops from requester 1; MULHU response held off 10 cycles.
    lat = 1;
    do_req(1, 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'hA);
    push(1'b1, 4'hA, 32'hFFFF_FFFE, 1'b0);
    get_resp(10, n);
    chk("latency_l1", 64'(n), 64'(lat + 1));
    do_req(1, 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'hB);
    push(1'b1, 4'hB, 32'h0000_0000, 1'b0);
    get_resp(0, n);
    do_req(1, 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'hC);
    push(1'b1, 4'hC, 32'hFFFF_FFFF, 1'b0);
    get_resp(0, n);
    do_req(0, 2'd1, 32'h8000_0000, 32'h8000_0000, 4'hD);
    push(1'b0, 4'hD, 32'h4000_0000, 1'b0);
    get_resp(0, n);

    // Multiplier not ready: issue held back; MULHSU operand extension.
    lat = 2;
    mul_ready = 1'b0;
    do_req(0, 2'd2, 32'h8000_0001, 32'h9000_0000, 4'h4);
    push(1'b0, 4'h4, ref_mul(2'd2, 32'h8000_0001, 32'h9000_0000), 1'b0);
    chk("ext_mcand", mul_multiplicand, 64'hFFFF_FFFF_8000_0001);
    chk("ext_mplier", mul_multiplier, 64'h0000_0000_9000_0000);
    seen = 1'b0;
    repeat (5) begin
      #1;
      seen = seen | mul_valid;
      @(negedge clk);
    end
    chk("issue_wait_ready", 64'(seen), 64'd0);
    mul_ready = 1'b1;
    #1;
    chk("issue_on_ready", 64'(mul_valid), 64'd1);
    get_resp(0, n);

    // kill in IDLE blocks the grant for that cycle.
    kill = 1'b1;
    req_valid[0] = 1'b1;
    #1;
    chk("kill_idle_nogrant", 64'(req_ready), 64'd0);
    @(negedge clk);
    kill = 1'b0;
    do_req(0, 2'd0, 32'd11, 32'd13, 4'h5);
    push(1'b0, 4'h5, 32'd143, 1'b0);
    get_resp(0, n);

    // kill five cycles into WAIT: one flush pulse, no response.
    lat = 20;
    do_req(0, 2'd0, 32'd5, 32'd6, 4'h6);
    repeat (6) @(negedge clk);
    kill = 1'b1;
    #1;
    chk("kill_wait_cycle", 64'({mul_flush, mul_valid}), 64'd0);
    @(negedge clk);
    kill = 1'b0;
    chk("kill_wait_flush", 64'({mul_flush, mul_valid}), 64'b10);
    @(negedge clk);
    chk("kill_wait_flush_end", 64'(mul_flush), 64'd0);
    seen = 1'b0;
    repeat (30) begin
      seen = seen | resp_valid;
      @(negedge clk);
    end
    chk("kill_wait_noresp", 64'(seen), 64'd0);
    lat = 3;
    do_req(1, 2'd0, 32'h1234_5678, 32'h10, 4'h7);
    push(1'b1, 4'h7, 32'h2345_6780, 1'b0);
    get_resp(0, n);
    chk("after_kill_latency", 64'(n), 64'(lat + 1));

    // kill in RESP drops the pending response.
    do_req(0, 2'd3, 32'h0001_0000, 32'h0001_0000, 4'h8);
    n = 0;
    while (!resp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("kill_resp_pending", 64'(resp_valid), 64'd1);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill_resp_drop", 64'(resp_valid), 64'd0);

    // Watchdog: stub never answers.
    stub_never = 1'b1;
    do_req(1, 2'd0, 32'd2, 32'd2, 4'h9);
    push(1'b1, 4'h9, 32'd0, 1'b1);
    n = 0;
    while (!mul_flush && n < 80) begin
      @(negedge clk);
      n++;
    end
    chk("wdog_cycles", 64'(n), 64'(WD + 1));
    chk("wdog_resp_valid", 64'(resp_valid), 64'd1);
    get_resp(0, n);
    chk("wdog_flush_pulse", 64'(mul_flush), 64'd0);
    stub_never = 1'b0;

    // rst during WAIT after a grant to requester 0.
    lat = 20;
    do_req(0, 2'd3, 32'hDEAD_BEEF, 32'h1234, 4'hE);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    set_payload(0, 5);
    set_payload(1, 5);
    req_valid = 2'b11;
    #1;
    check_reset_outputs("rstwait");
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      seen = seen | mul_flush;
    end
    rst = 1'b0;
    #1;
    chk("rst_no_flush", 64'(seen | mul_flush), 64'd0);
    chk("rr_ptr_reset", 64'(req_ready), 64'b01);
    req_valid[1] = 1'b0;
    lat = 2;
    do_req(0, 2'd0, 32'd9, 32'd9, 4'h2);
    push(1'b0, 4'h2, 32'd81, 1'b0);
    get_resp(0, n);

    // Random operations against the reference model.
    for (int i = 0; i < 6; i++) begin
      r   = int'($urandom_range(1, 0));
      op  = 2'($urandom_range(3, 0));
      a   = $urandom;
      b   = $urandom;
      tg  = TW'($urandom_range(15, 0));
      lat = int'($urandom_range(5, 1));
      do_req(r, op, a, b, tg);
      push(1'(r), tg, ref_mul(op, a, b), 1'b0);
      get_resp(0, n);
      chk("rand_latency", 64'(n), 64'(lat + 1));
    end

    repeat (3) @(negedge clk);
    chk("protocol_viol", 64'(viol), 64'd0);
    chk("sb_drained", 64'(scb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ysyx_22041207_mul_ctrl.md
YSYX_22041207_MUL_CTRL -- requirements
Module: ysyx_22041207_mul_ctrl

Interface
REQ-001 Parameter TAG_W, default 4, width of the requester transaction tag.
REQ-002 Parameter WDOG, default 48, maximum cycles in WAIT before a timeout.
REQ-003 clk  in  1  single clock; all state is updated on the posedge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 req_valid[1:0]  in  2  per-requester request valid.
REQ-006 req_ready[1:0]  out  2  per-requester accept; at most one bit is high in a cycle.
REQ-007 req_op[1:0][1:0]  in  2x2  operation per requester: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU.
REQ-008 req_src1[1:0][31:0], req_src2[1:0][31:0]  in  2x32  operands per requester.
REQ-009 req_tag[1:0][TAG_W-1:0]  in  2xTAG_W  transaction tag, returned with the response.
REQ-010 resp_valid  out  1; resp_id  out  1; resp_tag  out  TAG_W; resp_data  out  32; resp_err  out  1; resp_ready  in  1.
REQ-011 kill  in  1  pipeline flush; abandons the in-flight operation.
REQ-012 mul_valid  out  1; mul_flush  out  1; mul_multiplicand  out  64; mul_multiplier  out  64.
REQ-013 mul_ready  in  1; mul_out_valid  in  1; mul_result_hi  in  32; mul_result_lo  in  32.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT and RESP.
REQ-015 IDLE: if any req_valid is high and kill is low, the block SHALL grant one requester by round-robin, pulse its req_ready, latch op/src/tag/id, and move to ISSUE.
REQ-016 Round-robin: after a grant to requester N, requester 1-N SHALL win the next simultaneous contest; the round-robin pointer SHALL be 0 after reset.
REQ-017 Operand extension: src1 SHALL be sign-extended for MULH and MULHSU and zero-extended otherwise; src2 SHALL be sign-extended for MULH only and zero-extended otherwise; both are extended to 64 bits.
REQ-018 ISSUE: mul_valid SHALL be asserted for exactly one cycle, and only in a cycle where mul_ready is high; the FSM SHALL then move to WAIT and clear the watchdog counter.
REQ-019 WAIT: on mul_out_valid the block SHALL capture resp_data as mul_result_lo for MUL or mul_result_hi otherwise, set resp_err=0, and move to RESP.
REQ-020 WAIT watchdog: the counter SHALL increment each WAIT cycle; if it reaches WDOG, the block SHALL pulse mul_flush, set resp_data=0 and resp_err=1, and move to RESP.
REQ-021 RESP: resp_valid and all resp_* outputs SHALL be held stable until resp_ready is high; then the FSM SHALL move to IDLE, with no grant in that same cycle.
REQ-022 kill in ISSUE or WAIT: the block SHALL drive mul_flush high for one cycle with mul_valid low, discard the operation, produce no response, and return to IDLE.
REQ-023 kill in RESP: the pending response SHALL be dropped (resp_valid low next cycle) and the FSM SHALL return to IDLE.
REQ-024 kill in IDLE: the block SHALL grant nothing that cycle.
REQ-025 mul_out_valid outside WAIT SHALL be ignored.
REQ-026 Best-case latency from grant to resp_valid SHALL be 2 cycles plus the multiplier latency.

Reset
REQ-027 On rst the FSM SHALL go to IDLE, and the round-robin pointer and watchdog counter SHALL be set to 0.
REQ-028 On rst these outputs SHALL be 0: req_ready, resp_valid, resp_id, resp_tag, resp_data, resp_err, mul_valid, mul_flush, mul_multiplicand, mul_multiplier.
REQ-029 rst asserted mid-operation SHALL discard the operation with no response; the block SHALL NOT issue mul_flush, because the multiplier is reset concurrently.

Structure
REQ-030 The shared package SHALL hold the op encoding (MUL/MULH/MULHSU/MULHU), the FSM state enum, and the default TAG_W and WDOG values.
REQ-031 The round-robin grant logic SHALL be one sub-module, ysyx_22041207_rr_arb2; everything else SHALL be inline.

Verification
REQ-032 Requester 0 sends MUL 3 x 0xFFFFFFFE -> response id=0, data=0xFFFFFFFA, err=0.
REQ-033 Requester 1 sends MULHU 0xFFFFFFFF x 0xFFFFFFFF -> data=0xFFFFFFFE; MULH with the same operands -> data=0x00000000; MULHSU with the same operands -> data=0xFFFFFFFF.
REQ-034 Both requesters valid continuously from reset -> grant order 0,1,0,1, with tags returned in that order.
REQ-035 kill asserted 5 cycles into WAIT -> one-cycle mul_flush, no resp_valid, and the next request completes correctly.
REQ-036 Multiplier stub never asserts mul_out_valid -> after WDOG=48 WAIT cycles, mul_flush pulses and the response has resp_err=1, data=0.
REQ-037 rst asserted during WAIT, and separately resp_ready held low for 10 cycles in RESP -> reset values on all outputs / resp_* held stable for all 10 cycles.
